// File: rtl/cache_fill_arbiter_pkg.sv
// Shared memory-side types and constants for the cache fill arbiter.
// Block geometry is fixed: 16-byte blocks of eight 16-bit words.
package cpu_mem_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int WORDS_PER_BLK = 8;
    localparam int MEM_LATENCY   = 4;
    localparam int BLK_OFFSET_W  = 4;
    localparam int WORD_IDX_W    = 3;

    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((1 << BLK_OFFSET_W) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        FILL_I,
        FILL_D,
        DONE
    } arb_state_t;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter.
// master = arbiter, slave = caches plus memory model.
interface cache_fill_arbiter_if;
    import cpu_mem_pkg::*;

    logic                  icache_miss;
    logic [ADDR_W-1:0]     icache_miss_addr;
    logic                  dcache_miss;
    logic [ADDR_W-1:0]     dcache_miss_addr;
    logic                  dcache_wr;
    logic [ADDR_W-1:0]     dcache_wr_addr;
    logic [DATA_W-1:0]     dcache_wr_data;
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     mem_data_out;
    logic                  mem_data_valid;
    logic [DATA_W-1:0]     fill_data;
    logic [WORD_IDX_W-1:0] fill_word_idx;
    logic                  icache_fill_we;
    logic                  dcache_fill_we;
    logic                  icache_fill_done;
    logic                  dcache_fill_done;
    logic                  wr_ack;
    logic                  busy;

    modport master (
        input  icache_miss, icache_miss_addr,
        input  dcache_miss, dcache_miss_addr,
        input  dcache_wr, dcache_wr_addr, dcache_wr_data,
        input  mem_data_out, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_data_in,
        output fill_data, fill_word_idx,
        output icache_fill_we, dcache_fill_we,
        output icache_fill_done, dcache_fill_done,
        output wr_ack, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr,
        output dcache_miss, dcache_miss_addr,
        output dcache_wr, dcache_wr_addr, dcache_wr_data,
        output mem_data_out, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_data_in,
        input  fill_data, fill_word_idx,
        input  icache_fill_we, dcache_fill_we,
        input  icache_fill_done, dcache_fill_done,
        input  wr_ack, busy
    );

endinterface

// File: rtl/cache_fill_arbiter_fill_sequencer.sv
// Issue/receive counters and word-address generation for one block fill.
// Shared by both caches; the arbiter selects which cache receives the words.
module fill_sequencer
    import cpu_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  active,
    input  logic                  rx_en,
    input  logic                  mem_data_valid,
    input  logic [ADDR_W-1:0]     blk_addr,
    output logic                  issue_en,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [WORD_IDX_W-1:0] word_idx,
    output logic                  fill_we,
    output logic                  last_word
);

    logic [WORD_IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_W-1:0] recv_cnt_q, recv_cnt_d;
    logic                  issued_all_q, issued_all_d;

    // The 3-bit issue counter wraps; issued_all stops a second pass.
    assign issue_en  = active && !issued_all_q;
    assign fill_we   = rx_en && mem_data_valid;
    assign last_word = fill_we && (recv_cnt_q == WORD_IDX_W'(WORDS_PER_BLK - 1));
    assign word_idx  = fill_we ? recv_cnt_q : '0;
    assign rd_addr   = issue_en
                     ? ((blk_addr & BLK_MASK) | ADDR_W'({issue_cnt_q, 1'b0}))
                     : '0;

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        issued_all_d = issued_all_q;
        if (start) begin
            issue_cnt_d  = '0;
            recv_cnt_d   = '0;
            issued_all_d = 1'b0;
        end else begin
            if (issue_en) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == WORD_IDX_W'(WORDS_PER_BLK - 1))
                    issued_all_d = 1'b1;
            end
            if (fill_we)
                recv_cnt_d = recv_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            issued_all_q <= 1'b0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            issued_all_q <= issued_all_d;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Schedules I-fills, D-fills and D write-through stores onto main memory.
// D-side has priority except right after a D-side grant when I is waiting.
module cache_fill_arbiter
    import cpu_mem_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    cache_fill_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              last_was_d_q, last_was_d_d;
    logic              is_d_q, is_d_d;
    logic              wr_ack_q, wr_ack_d;

    logic              start, fill_active, rx_en;
    logic              issue_en, fill_we, last_word;
    logic [ADDR_W-1:0] rd_addr;

    assign fill_active = (state_q == FILL_I) || (state_q == FILL_D);
    assign rx_en       = fill_active || (state_q == DONE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        last_was_d_d = last_was_d_q;
        is_d_d       = is_d_q;
        wr_ack_d     = 1'b0;
        start        = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A store still high during its ack cycle is the one just served.
                if (bus.icache_miss && last_was_d_q) begin
                    state_d = FILL_I;
                    addr_d  = bus.icache_miss_addr;
                    is_d_d  = 1'b0;
                    start   = 1'b1;
                end else if (bus.dcache_wr && !wr_ack_q) begin
                    state_d   = STORE;
                    addr_d    = bus.dcache_wr_addr;
                    wr_data_d = bus.dcache_wr_data;
                    is_d_d    = 1'b1;
                end else if (bus.dcache_miss) begin
                    state_d = FILL_D;
                    addr_d  = bus.dcache_miss_addr;
                    is_d_d  = 1'b1;
                    start   = 1'b1;
                end else if (bus.icache_miss) begin
                    state_d = FILL_I;
                    addr_d  = bus.icache_miss_addr;
                    is_d_d  = 1'b0;
                    start   = 1'b1;
                end
            end
            STORE: begin
                state_d      = IDLE;
                wr_ack_d     = 1'b1;
                last_was_d_d = 1'b1;
            end
            FILL_I, FILL_D: begin
                if (last_word)
                    state_d = DONE;
            end
            DONE: begin
                state_d      = IDLE;
                last_was_d_d = is_d_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wr_data_q    <= '0;
            last_was_d_q <= 1'b0;
            is_d_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            last_was_d_q <= last_was_d_d;
            is_d_q       <= is_d_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    fill_sequencer u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .active         (fill_active),
        .rx_en          (rx_en),
        .mem_data_valid (bus.mem_data_valid),
        .blk_addr       (addr_q),
        .issue_en       (issue_en),
        .rd_addr        (rd_addr),
        .word_idx       (bus.fill_word_idx),
        .fill_we        (fill_we),
        .last_word      (last_word)
    );

    assign bus.mem_en           = (state_q == STORE) || issue_en;
    assign bus.mem_wr           = (state_q == STORE);
    assign bus.mem_addr         = (state_q == STORE) ? (addr_q & WORD_MASK) : rd_addr;
    assign bus.mem_data_in      = (state_q == STORE) ? wr_data_q : '0;
    assign bus.fill_data        = bus.mem_data_out;
    assign bus.icache_fill_we   = fill_we && !is_d_q;
    assign bus.dcache_fill_we   = fill_we && is_d_q;
    assign bus.icache_fill_done = (state_q == DONE) && !is_d_q;
    assign bus.dcache_fill_done = (state_q == DONE) && is_d_q;
    assign bus.wr_ack           = wr_ack_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model.
// Memory returns 0xA000 + word index of each read.
module tb_cache_fill_arbiter;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    cache_fill_arbiter_if bus ();

    cache_fill_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [MEM_LATENCY-1:0] pv;
    logic [2:0]             pidx [MEM_LATENCY];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) pidx[i] <= '0;
        end else begin
            pv      <= {pv[MEM_LATENCY-2:0], bus.mem_en && !bus.mem_wr};
            pidx[0] <= bus.mem_addr[3:1];
            for (int i = 1; i < MEM_LATENCY; i++) pidx[i] <= pidx[i-1];
        end
    end

    assign bus.mem_data_valid = pv[MEM_LATENCY-1];
    assign bus.mem_data_out   = pv[MEM_LATENCY-1]
                              ? (16'hA000 + 16'(pidx[MEM_LATENCY-1])) : 16'h0000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 after the grant edge; returns in the idle cycle 14.
    task automatic fill_seq(input bit is_d, input logic [15:0] blk);
        for (int c = 1; c <= 13; c++) begin
            bit          iss;
            bit          rx;
            logic [15:0] ea;
            iss = (c <= 8);
            rx  = (c >= 5) && (c <= 12);
            ea  = iss ? (blk + 16'(2 * (c - 1))) : 16'h0000;
            check("busy", 32'(bus.busy), 32'(1));
            check("mem_en", 32'(bus.mem_en), 32'(iss));
            check("mem_wr", 32'(bus.mem_wr), 32'(0));
            check("mem_addr", 32'(bus.mem_addr), 32'(ea));
            check("i_we", 32'(bus.icache_fill_we), 32'(rx && !is_d));
            check("d_we", 32'(bus.dcache_fill_we), 32'(rx && is_d));
            check("idx", 32'(bus.fill_word_idx), rx ? 32'(c - 5) : 32'(0));
            if (rx)
                check("fill_data", 32'(bus.fill_data), 32'(16'hA000 + 16'(c - 5)));
            check("i_done", 32'(bus.icache_fill_done), 32'(c == 13 && !is_d));
            check("d_done", 32'(bus.dcache_fill_done), 32'(c == 13 && is_d));
            check("wr_ack", 32'(bus.wr_ack), 32'(0));
            if (c == 13) begin
                if (is_d) bus.dcache_miss = 1'b0;
                else      bus.icache_miss = 1'b0;
            end
            tick();
        end
        check("busy_after", 32'(bus.busy), 32'(0));
        check("i_done_after", 32'(bus.icache_fill_done), 32'(0));
        check("d_done_after", 32'(bus.dcache_fill_done), 32'(0));
    endtask

    initial begin
        bus.icache_miss      = 1'b0;
        bus.icache_miss_addr = 16'h0;
        bus.dcache_miss      = 1'b0;
        bus.dcache_miss_addr = 16'h0;
        bus.dcache_wr        = 1'b0;
        bus.dcache_wr_addr   = 16'h0;
        bus.dcache_wr_data   = 16'h0;

        #3;
        check("rst_mem_en", 32'(bus.mem_en), 32'(0));
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_mem_data_in", 32'(bus.mem_data_in), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_wr_ack", 32'(bus.wr_ack), 32'(0));
        check("rst_idx", 32'(bus.fill_word_idx), 32'(0));
        check("rst_fill_data", 32'(bus.fill_data), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Lone I-miss, unaligned address inside block 0x1230.
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h1236;
        tick();
        fill_seq(1'b0, 16'h1230);

        // Store, D-miss and I-miss together.
        bus.dcache_wr        = 1'b1;
        bus.dcache_wr_addr   = 16'h0040;
        bus.dcache_wr_data   = 16'hBEEF;
        bus.dcache_miss      = 1'b1;
        bus.dcache_miss_addr = 16'h2000;
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h0100;
        tick();
        check("st_mem_en", 32'(bus.mem_en), 32'(1));
        check("st_mem_wr", 32'(bus.mem_wr), 32'(1));
        check("st_mem_addr", 32'(bus.mem_addr), 32'(16'h0040));
        check("st_mem_data", 32'(bus.mem_data_in), 32'(16'hBEEF));
        check("st_busy", 32'(bus.busy), 32'(1));
        check("st_wr_ack0", 32'(bus.wr_ack), 32'(0));
        tick();
        check("st_wr_ack1", 32'(bus.wr_ack), 32'(1));
        check("st_mem_en_off", 32'(bus.mem_en), 32'(0));
        check("st_busy_off", 32'(bus.busy), 32'(0));
        bus.dcache_wr = 1'b0;
        tick();
        check("st_wr_ack_pulse", 32'(bus.wr_ack), 32'(0));
        fill_seq(1'b0, 16'h0100);
        tick();
        fill_seq(1'b1, 16'h2000);

        // Fresh history: D first, then I must slot in between D fills.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.dcache_miss      = 1'b1;
        bus.dcache_miss_addr = 16'h3000;
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h0500;
        tick();
        fill_seq(1'b1, 16'h3000);
        bus.dcache_miss      = 1'b1;
        bus.dcache_miss_addr = 16'h4000;
        tick();
        fill_seq(1'b0, 16'h0500);
        tick();
        fill_seq(1'b1, 16'h4000);

        // Reset in the middle of a fill, then re-presented miss.
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h0808;
        tick();
        for (int c = 1; c < 7; c++) tick();
        check("mid_we", 32'(bus.icache_fill_we), 32'(1));
        check("mid_idx", 32'(bus.fill_word_idx), 32'(2));
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.icache_fill_we), 32'(0));
        check("arst_idx", 32'(bus.fill_word_idx), 32'(0));
        check("arst_busy", 32'(bus.busy), 32'(0));
        check("arst_mem_en", 32'(bus.mem_en), 32'(0));
        check("arst_fill_data", 32'(bus.fill_data), 32'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("arst_no_done", 32'(bus.icache_fill_done), 32'(0));
        end
        rst_n = 1'b1;
        tick();
        fill_seq(1'b0, 16'h0800);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shares the single multi-cycle main memory between I-cache line fills, D-cache line fills and D-cache write-through stores in the 16-bit pipelined CPU.
- Sits between the two caches and the main-memory model.
- Owns grant selection, block-address sequencing, the outstanding-read count, and fill/ack pulses back to each cache.
- The pipeline stalls on the caches' miss lines; this block only schedules memory.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
WORDS_PER_BLK, 8, words per cache block (16-byte block)
MEM_LATENCY, 4, cycles from read issue to mem_data_valid

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
icache_miss  input  1  I-cache fill request, level, held until icache_fill_done
icache_miss_addr  input  16  I-cache miss byte address
dcache_miss  input  1  D-cache fill request, level, held until dcache_fill_done
dcache_miss_addr  input  16  D-cache miss byte address
dcache_wr  input  1  D-cache write-through store request, level, held until wr_ack
dcache_wr_addr  input  16  store byte address
dcache_wr_data  input  16  store data
mem_en  output  1  memory access this cycle
mem_wr  output  1  1 = write, 0 = read
mem_addr  output  16  memory byte address
mem_data_in  output  16  write data to memory
mem_data_out  input  16  read data from memory
mem_data_valid  input  1  mem_data_out valid, in issue order
fill_data  output  16  mem_data_out pass-through
fill_word_idx  output  3  block word index of fill_data
icache_fill_we  output  1  write fill_data into the I-cache block
dcache_fill_we  output  1  write fill_data into the D-cache block
icache_fill_done  output  1  one-cycle pulse: I-cache block complete
dcache_fill_done  output  1  one-cycle pulse: D-cache block complete
wr_ack  output  1  one-cycle pulse: store accepted by memory
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE, all counters 0, last_was_d 0.
- Reset values: every output 0, except fill_data, which follows mem_data_out.
- Main memory shares rst_n, so no stale mem_data_valid can follow reset.
- Reset mid-operation aborts the fill or store. Requesters re-present; no partial done or ack is issued.
- States: IDLE, STORE, FILL_I, FILL_D, DONE.
- IDLE grant priority: dcache_wr, then dcache_miss, then icache_miss.
  - Anti-starvation: if last_was_d == 1 and icache_miss is set, FILL_I wins over both D requests.
  - last_was_d is set on completion of a D-side grant and cleared on completion of FILL_I.
- The grant registers the chosen address; the address is captured on the grant edge.
- STORE (1 cycle):
  - mem_en = 1, mem_wr = 1, mem_addr = captured address, mem_data_in = dcache_wr_data.
  - Next cycle: wr_ack = 1, state goes to IDLE.
- FILL_x issue phase:
  - issue counter 0..7; each cycle drive mem_en = 1, mem_wr = 0.
  - mem_addr = {addr[15:4], issue_cnt, 1'b0}.
  - Issue order is word 0 first, not critical-word first.
- FILL_x receive phase:
  - Receive counter increments on each mem_data_valid.
  - Same cycle: fill_word_idx = recv_cnt and x-cache fill_we = 1, combinational from mem_data_valid.
- mem_data_valid while not in FILL_x or DONE is ignored; it must not occur by the memory contract.
- DONE is entered when recv_cnt wraps from 7 after the 8th word.
  - In DONE: the matching fill_done = 1 for one cycle, then IDLE.
  - A new grant is possible the next cycle.
- Timing, grant at edge 0: reads issue cycles 1-8, data valid cycles 5-12, fill_done cycle 13, next grant evaluated cycle 14.
- Store latency: store in cycle 1, wr_ack cycle 2.
- Requests arriving while busy wait. A request dropped before its grant is legal and simply not served.
- Counters are 3 bits and wrap naturally; the issue counter stops issuing after 8.
- Address bit 0 is ignored (word aligned).
- Combinational outputs are driven only from state, counters and the mem_data_valid pass-through. No latches.

Decomposition:
- Shared package cpu_mem_pkg:
  - typedef arb_state_t (IDLE, STORE, FILL_I, FILL_D, DONE)
  - BLK_OFFSET_W = 4
  - WORD_IDX_W = 3
  - MEM_LATENCY
- One sub-module, fill_sequencer:
  - issue and receive counters
  - address generation
  - fill_we / last-word detect
  - used once, with the target selected by the arbiter FSM.

Test Plan:
- icache_miss = 1, addr 0x1236, no D requests -> mem_addr 0x1230..0x123E over cycles 1-8, icache_fill_we with idx 0..7 over cycles 5-12, icache_fill_done at cycle 13, dcache_* outputs stay 0.
- dcache_wr with addr 0x0040, data 0xBEEF, raised at the same time as dcache_miss 0x2000 and icache_miss 0x0100:
  - store first: mem_wr = 1, addr 0x0040, data 0xBEEF; wr_ack next cycle.
  - then FILL_I (last_was_d set), then FILL_D.
- Back-to-back dcache_miss (addresses 0x3000 then 0x4000) with icache_miss held -> I fill is granted between the two D fills; no starvation.
- rst_n pulled low at fill cycle 7 (word 2 received) -> all outputs 0 asynchronously, no fill_done; after release, a re-presented miss completes a full 8 words.
- Memory model returning 0xA000 + idx -> fill_data/fill_word_idx pairs match exactly; busy = 1 from the grant edge through the DONE cycle, then 0.
